// File: rtl/bf16_pkg.sv
// Shared BF16 types, constants and packing helper for the shared-multiplier scheduler.
package bf16_pkg;

   localparam int          BF16_BIAS   = 127;
   localparam logic [15:0] BF16_MAXFIN = 16'h7F7F;

   typedef struct packed {
      logic       sign;
      logic [7:0] exp;
      logic [6:0] frac;
   } bf16_t;

   function automatic logic [15:0] bf16_pack(input logic s, input logic [7:0] e, input logic [6:0] f);
      return {s, e, f};
   endfunction

endpackage

// File: rtl/bf16_mul_core.sv
// Combinational BF16 multiplier: truncating, saturates on overflow, flushes subnormal results to zero.
module bf16_mul_core
   import bf16_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] data,
   output logic        ovf,
   output logic        unf
);

   bf16_t       w_a;
   bf16_t       w_b;
   logic        w_sign;
   logic [15:0] w_m;
   logic [9:0]  w_esum;
   logic [9:0]  w_e;
   logic [6:0]  w_frac;

   assign w_a    = a;
   assign w_b    = b;
   assign w_sign = w_a.sign ^ w_b.sign;
   assign w_m    = {8'd0, 1'b1, w_a.frac} * {8'd0, 1'b1, w_b.frac};
   assign w_esum = {2'b00, w_a.exp} + {2'b00, w_b.exp};

   // A product in [2,4) needs one extra normalising shift, which bumps the exponent by one.
   assign w_e    = w_m[15] ? (w_esum - 10'(BF16_BIAS - 1)) : (w_esum - 10'(BF16_BIAS));
   assign w_frac = w_m[15] ? 7'(w_m >> 8) : 7'(w_m >> 7);

   always_comb begin
      data = bf16_pack(w_sign, w_e[7:0], w_frac);
      ovf  = 1'b0;
      unf  = 1'b0;
      if (w_a.exp == 8'd0 || w_b.exp == 8'd0) begin
         data = bf16_pack(w_sign, 8'h00, 7'h00);
      end else if ($signed(w_e) <= 10'sd0) begin
         data = bf16_pack(w_sign, 8'h00, 7'h00);
         unf  = 1'b1;
      end else if ($signed(w_e) >= 10'sd255) begin
         data = {w_sign, BF16_MAXFIN[14:0]};
         ovf  = 1'b1;
      end
   end

endmodule

// File: rtl/bf16_mul_sched.sv
// Round-robin arbiter feeding one shared BF16 multiplier through a two-stage back-pressured pipeline.
module bf16_mul_sched
   import bf16_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [16*NREQ-1:0]   req_a,
   input  logic [16*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [15:0]          res_data,
   output logic [IDW-1:0]       res_id,
   output logic                 res_ovf,
   output logic                 res_unf
);

   logic [IDW-1:0] r_last;
   logic           r_s1_valid;
   logic [15:0]    r_s1_a;
   logic [15:0]    r_s1_b;
   logic [IDW-1:0] r_s1_id;
   logic           r_s2_valid;
   logic [15:0]    r_s2_data;
   logic [IDW-1:0] r_s2_id;
   logic           r_s2_ovf;
   logic           r_s2_unf;

   logic [15:0]    w_a_arr   [NREQ];
   logic [15:0]    w_b_arr   [NREQ];
   logic [IDW:0]   w_sum     [NREQ];
   logic [IDW-1:0] w_cand_id [NREQ];
   logic           w_found;
   logic [IDW-1:0] w_gid;
   logic [NREQ-1:0] w_ready;
   logic           w_hs;
   logic           w_adv1;
   logic           w_adv2;
   logic [15:0]    w_mul_data;
   logic           w_mul_ovf;
   logic           w_mul_unf;

   // Candidate gi is the requester (gi+1) places after the last accepted one, modulo NREQ.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign w_a_arr[gi]   = req_a[16*gi +: 16];
         assign w_b_arr[gi]   = req_b[16*gi +: 16];
         assign w_sum[gi]     = {1'b0, r_last} + (IDW+1)'(gi + 1);
         assign w_cand_id[gi] = (w_sum[gi] >= (IDW+1)'(NREQ)) ? IDW'(w_sum[gi] - (IDW+1)'(NREQ))
                                                              : w_sum[gi][IDW-1:0];
      end
   endgenerate

   always_comb begin
      w_found = 1'b0;
      w_gid   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[w_cand_id[k]]) begin
            w_found = 1'b1;
            w_gid   = w_cand_id[k];
         end
      end
   end

   assign w_adv2    = !r_s2_valid || res_ready;
   assign w_adv1    = !r_s1_valid || w_adv2;
   assign w_ready   = (w_found && w_adv1 && !rst) ? (NREQ'(1) << w_gid) : '0;
   assign w_hs      = |(req_valid & w_ready);
   assign req_ready = w_ready;

   bf16_mul_core u_core (
      .a    (r_s1_a),
      .b    (r_s1_b),
      .data (w_mul_data),
      .ovf  (w_mul_ovf),
      .unf  (w_mul_unf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last     <= IDW'(NREQ - 1);
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_id    <= '0;
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_id    <= '0;
         r_s2_ovf   <= 1'b0;
         r_s2_unf   <= 1'b0;
      end else begin
         if (w_hs) begin
            r_last <= w_gid;
         end
         if (w_adv1) begin
            r_s1_valid <= w_hs;
            if (w_hs) begin
               r_s1_a  <= w_a_arr[w_gid];
               r_s1_b  <= w_b_arr[w_gid];
               r_s1_id <= w_gid;
            end
         end
         // Result fields only move when a real operation advances, keeping idle outputs quiet.
         if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_data <= w_mul_data;
               r_s2_id   <= r_s1_id;
               r_s2_ovf  <= w_mul_ovf;
               r_s2_unf  <= w_mul_unf;
            end
         end
      end
   end

   assign res_valid = r_s2_valid;
   assign res_data  = r_s2_data;
   assign res_id    = r_s2_id;
   assign res_ovf   = r_s2_ovf;
   assign res_unf   = r_s2_unf;

endmodule

// File: tb/tb_bf16_mul_sched.sv
// Scoreboard bench: the driver pushes the hand-computed product on every predicted grant, a monitor pops on each result.
module tb_bf16_mul_sched;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [16*NREQ-1:0]  req_a;
   logic [16*NREQ-1:0]  req_b;
   logic [NREQ-1:0]     req_ready;
   logic                res_valid;
   logic                res_ready;
   logic [15:0]         res_data;
   logic [IDW-1:0]      res_id;
   logic                res_ovf;
   logic                res_unf;

   always #5 clk = ~clk;

   bf16_mul_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id),
      .res_ovf   (res_ovf),
      .res_unf   (res_unf)
   );

   typedef struct packed {
      logic [15:0]    data;
      logic [IDW-1:0] id;
      logic           ovf;
      logic           unf;
   } exp_t;

   exp_t            sb_q[$];
   int              checks = 0;
   int              fails  = 0;
   logic [15:0]     exp_d [NREQ];
   logic            exp_o [NREQ];
   logic            exp_u [NREQ];
   logic            m_s1;
   logic            m_s2;
   int              m_last;
   logic [NREQ-1:0] hs_mask;
   logic [NREQ-1:0] dut_hs;
   bit              one_shot;
   bit              held;
   exp_t            held_v;
   exp_t            mon_e;
   int              accepted;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // One clock: check grants and pipeline occupancy against the reference model, push expectations.
   task automatic step();
      logic            adv1;
      logic            adv2;
      int              g;
      int              idx;
      logic [NREQ-1:0] exp_rdy;
      exp_t            e;
      @(negedge clk);
      chk("res_valid", res_valid, m_s2);
      adv2 = !m_s2 || res_ready;
      adv1 = !m_s1 || adv2;
      g = -1;
      if (!rst && adv1) begin
         for (int k = 1; k <= NREQ; k++) begin
            idx = (m_last + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
      chk("req_ready", req_ready, exp_rdy);
      dut_hs = req_valid & req_ready;
      hs_mask = '0;
      if (rst) begin
         m_s1 = 1'b0;
         m_s2 = 1'b0;
         m_last = NREQ - 1;
         sb_q.delete();
      end else begin
         if (adv2) m_s2 = m_s1;
         if (adv1) m_s1 = (g >= 0);
         if (g >= 0) begin
            m_last  = g;
            e       = '{data: exp_d[g], id: IDW'(g), ovf: exp_o[g], unf: exp_u[g]};
            sb_q.push_back(e);
            hs_mask = exp_rdy;
         end
      end
      @(posedge clk);
      #1;
      if (one_shot) req_valid = req_valid & ~hs_mask;
   endtask

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ed, input logic eo, input logic eu);
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
      exp_d[i] = ed;
      exp_o[i] = eo;
      exp_u[i] = eu;
   endtask

   task automatic send(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ed, input logic eo, input logic eu);
      int n;
      set_req(i, a, b, ed, eo, eu);
      req_valid[i] = 1'b1;
      n = 0;
      while (req_valid[i] && n < 20) begin
         step();
         n++;
      end
      if (req_valid[i]) begin
         chk("send_timeout", 32'(req_valid[i]), 32'd0);
         req_valid[i] = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() > 0 && n < 30) begin
         step();
         n++;
      end
      chk("drain_left", 32'(sb_q.size()), 32'd0);
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Monitor: pops one expectation per accepted result and checks hold stability while stalled.
   always @(negedge clk) begin
      if (!rst && res_valid) begin
         if (held) begin
            chk("hold_stable", {res_data, res_id, res_ovf, res_unf}, held_v);
         end
         if (res_ready) begin
            held = 1'b0;
            if (sb_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL res_unexpected: got data %0h id %0d expected no result", res_data, res_id);
            end else begin
               mon_e = sb_q.pop_front();
               chk("res_data", res_data, mon_e.data);
               chk("res_id",   res_id,   mon_e.id);
               chk("res_ovf",  res_ovf,  mon_e.ovf);
               chk("res_unf",  res_unf,  mon_e.unf);
               $display("result id=%0d data=%04h ovf=%0d unf=%0d", res_id, res_data, res_ovf, res_unf);
            end
         end else begin
            held   = 1'b1;
            held_v = '{data: res_data, id: res_id, ovf: res_ovf, unf: res_unf};
         end
      end else begin
         held = 1'b0;
      end
   end

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b1;
      one_shot  = 1'b1;
      held      = 1'b0;
      m_s1      = 1'b0;
      m_s2      = 1'b0;
      m_last    = NREQ - 1;
      hs_mask   = '0;
      dut_hs    = '0;
      for (int i = 0; i < NREQ; i++) begin
         exp_d[i] = 16'h0000;
         exp_o[i] = 1'b0;
         exp_u[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data",  res_data,  0);
      chk("rst_res_id",    res_id,    0);
      chk("rst_res_ovf",   res_ovf,   0);
      chk("rst_res_unf",   res_unf,   0);
      do_reset();

      // single requester and normalisation cases
      send(0, 16'h3FC0, 16'h3FC0, 16'h4010, 1'b0, 1'b0);
      drain();
      send(0, 16'h4000, 16'h4040, 16'h40C0, 1'b0, 1'b0);
      send(0, 16'hBF80, 16'h3F80, 16'hBF80, 1'b0, 1'b0);
      drain();

      // saturation, flush-to-zero and zero operand
      send(1, 16'h7F00, 16'h7F00, 16'h7F7F, 1'b1, 1'b0);
      send(2, 16'h0080, 16'h3F00, 16'h0000, 1'b0, 1'b1);
      send(3, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0);
      drain();

      // round robin with all four requesters continuously valid
      do_reset();
      one_shot = 1'b0;
      set_req(0, 16'h3FC0, 16'h3FC0, 16'h4010, 1'b0, 1'b0);
      set_req(1, 16'h4000, 16'h4040, 16'h40C0, 1'b0, 1'b0);
      set_req(2, 16'hBF80, 16'h3F80, 16'hBF80, 1'b0, 1'b0);
      set_req(3, 16'hC000, 16'h4000, 16'hC080, 1'b0, 1'b0);
      req_valid = 4'hF;
      accepted = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("rr_grant", dut_hs, 4'b0001 << (c % NREQ));
         accepted += $countones(dut_hs);
      end
      chk("rr_count", accepted, 8);
      req_valid = '0;
      one_shot = 1'b1;
      drain();

      // backpressure: downstream stalled for five cycles
      res_ready = 1'b0;
      set_req(1, 16'h3F80, 16'h3F80, 16'h3F80, 1'b0, 1'b0);
      set_req(2, 16'h4040, 16'h4040, 16'h4110, 1'b0, 1'b0);
      req_valid = 4'b0110;
      accepted = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         accepted += $countones(dut_hs);
      end
      chk("bp_accepted", accepted, 2);
      res_ready = 1'b1;
      drain();

      // reset with both pipeline stages occupied
      res_ready = 1'b0;
      set_req(0, 16'h3FC0, 16'h3FC0, 16'h4010, 1'b0, 1'b0);
      set_req(1, 16'h4000, 16'h4040, 16'h40C0, 1'b0, 1'b0);
      req_valid = 4'b0011;
      step();
      step();
      chk("mid_s2_full", res_valid, 1);
      set_req(2, 16'hBF80, 16'h3F80, 16'hBF80, 1'b0, 1'b0);
      set_req(3, 16'hC000, 16'h4000, 16'hC080, 1'b0, 1'b0);
      req_valid = 4'hF;
      res_ready = 1'b1;
      do_reset();
      chk("post_rst_res_valid", res_valid, 0);
      step();
      chk("post_rst_grant", dut_hs, 4'b0001);
      req_valid = '0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
